encoder_period_meter: RTL

- Parametrised successor to the single-channel encoder period reader.
- Measures clock cycles between qualified encoder edges, with:
  - input synchroniser and glitch filter
  - selectable edge mode
  - stall timeout
  - sliding-window average over the last 2^AVG_LOG2 periods
- Feeds the speed control loop, which consumes period_avg, in place of the raw single-period reading.

---
 rtl/encoder_period_meter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/encoder_period_meter.sv
// Encoder period meter: measures clocks between qualified encoder edges after a
// synchroniser and glitch filter. It flags a stall when no edge arrives within TIMEOUT
// and averages the last 2^AVG_LOG2 periods for the speed loop.
module encoder_period_meter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             encoder,
  input  logic [1:0]       edge_sel,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [WIDTH-1:0] period_avg,
  output logic             avg_valid,
  output logic             stalled
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned RUN_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W  = WIDTH + AVG_LOG2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt_q;
  logic                   filt_dly_q;
  logic [RUN_W-1:0]       run_q;
  logic                   qual_q;
  logic [WIDTH-1:0]       cnt_q;
  logic                   armed_q;
  logic                   push_q;
  logic                   take;
  logic                   hit;
  logic                   flush;

  logic [WIDTH-1:0]       win_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [FILL_W-1:0]      fill_q;
  logic [SUM_W-1:0]       sum_q;
  logic [WIDTH-1:0]       old_entry;
  logic [SUM_W-1:0]       sum_next;
  logic [FILL_W-1:0]      fill_next;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain for the asynchronous encoder input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], encoder};
    end
  end

  // Glitch filter: accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else if (sync_out != filt_q) begin
      if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        filt_q <= sync_out;
        run_q  <= '0;
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
    end else begin
      run_q <= '0;
    end
  end

  // Registered edge qualification, so an edge_sel change applies from the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_dly_q <= 1'b0;
      qual_q     <= 1'b0;
    end else begin
      filt_dly_q <= filt_q;
      qual_q     <= (filt_q & ~filt_dly_q & edge_sel[0]) | (~filt_q & filt_dly_q & edge_sel[1]);
    end
  end

  // Event decode: clear beats a qualified edge, and a qualified edge beats the timeout.
  always_comb begin
    take  = qual_q & ~clear;
    hit   = ~clear & ~qual_q & (cnt_q == WIDTH'(TIMEOUT));
    flush = clear | hit;
  end

  // Period counter, arming, stall detection and the period output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      push_q       <= 1'b0;
      period       <= '1;
      period_valid <= 1'b0;
      stalled      <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      push_q       <= take & armed_q;
      if (clear) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (take) begin
        cnt_q <= WIDTH'(1);
        if (armed_q) begin
          period       <= cnt_q;
          period_valid <= 1'b1;
        end else begin
          armed_q <= 1'b1;
          stalled <= 1'b0;
        end
      end else begin
        // Saturating count; running past TIMEOUT is what prevents a repeat stall pulse.
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
        if (hit) begin
          stalled      <= 1'b1;
          armed_q      <= 1'b0;
          period       <= '1;
          period_valid <= 1'b1;
        end
      end
    end
  end

  // Entry leaving the window only counts once the window is full.
  always_comb begin
    old_entry = (fill_q == FILL_W'(DEPTH)) ? win_q[wr_ptr_q] : '0;
    sum_next  = sum_q + SUM_W'(period) - SUM_W'(old_entry);
    fill_next = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
  end

  // Sliding-window average, updated the cycle after each measured period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        win_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      period_avg <= '1;
      avg_valid  <= 1'b0;
    end else if (flush) begin
      fill_q     <= '0;
      sum_q      <= '0;
      period_avg <= '1;
      avg_valid  <= 1'b0;
    end else if (push_q) begin
      win_q[wr_ptr_q] <= period;
      wr_ptr_q        <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      sum_q           <= sum_next;
      fill_q          <= fill_next;
      if (fill_next == FILL_W'(DEPTH)) begin
        period_avg <= WIDTH'(sum_next >> AVG_LOG2);
        avg_valid  <= 1'b1;
      end
    end
  end

endmodule
